// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan path: glyph table, blank
// pattern and the digit-slot divider calculation.
package seg_pkg;

  // Segments ordered g..a, active-low; entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int DIV_MIN = 4;

  // Clocks per digit slot; clamped so every slot keeps its dark guard clock
  // plus some lit time.
  function automatic int calc_div(int clk_hz, int refresh_hz, int n_digits);
    int d;
    d = clk_hz / (refresh_hz * n_digits);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low g..a segment decode.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/scan_tick_gen.sv
// Digit slot counter: counts 0..DIV-1 and flags the last count as the tick.
module scan_tick_gen #(
  parameter int DIV   = 12,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] slot_cnt,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  assign tick = (slot_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) slot_cnt <= '0;
    else        slot_cnt <= tick ? '0 : slot_cnt + 1'b1;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// N-digit multiplexed seven-segment scanner with shadowed frame-synchronous
// loading, leading-zero blanking, decimal points and PWM brightness.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS         = 8,
  parameter int CLK_HZ           = 100_000_000,
  parameter int REFRESH_HZ       = 60,
  parameter int BRIGHT_W         = 4,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  load,
  output logic [N_DIGITS-1:0]   a,
  output logic [6:0]            cathodes,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int DIV   = calc_div(CLK_HZ, REFRESH_HZ, N_DIGITS);
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ANODE_OFF = ANODE_ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]    slot_cnt;
  logic                tick;
  logic                boundary;
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic                pending;

  logic [4*N_DIGITS-1:0] sh_data;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   sh_en;

  logic [N_DIGITS-1:0] blank_mask;
  logic [N_DIGITS-1:0] sel;
  logic [3:0]          cur_nib;
  logic [6:0]          glyph;
  logic                pwm_on;
  logic                lit;

  scan_tick_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .slot_cnt (slot_cnt),
    .tick     (tick)
  );

  assign boundary = tick && (idx == LAST_IDX);

  // Digit index, PWM phase and shadow capture. Shadows only change on the
  // frame boundary so a frame is always drawn from a single snapshot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx     <= '0;
      pwm_cnt <= '0;
      pending <= 1'b0;
      sh_data <= '0;
      sh_dp   <= '0;
      sh_en   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (boundary && (pending || load)) begin
        sh_data <= data;
        sh_dp   <= dp_in;
        sh_en   <= digit_en;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // A digit above 0 goes dark when it and every digit to its left are zero.
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_lz
    if (i == 0) begin : g_d0
      assign blank_mask[i] = 1'b0;
    end else begin : g_dn
      assign blank_mask[i] = blank_lz && (sh_data[4*N_DIGITS-1:4*i] == '0);
    end
  end

  assign cur_nib = sh_data[idx*4 +: 4];

  hex_to_7seg u_dec (
    .nib (cur_nib),
    .seg (glyph)
  );

  assign pwm_on = (&bright) || (pwm_cnt < bright);
  // Slot count 0 is the guard clock right after a digit change: no anode
  // is driven while the cathodes swap patterns.
  assign lit    = (slot_cnt != '0) && sh_en[idx] && !blank_mask[idx] && pwm_on;
  assign sel    = N_DIGITS'(1) << idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a          <= ANODE_OFF;
      cathodes   <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      a          <= (lit ? sel : '0) ^ ANODE_OFF;
      cathodes   <= lit ? glyph : SEG_OFF;
      dp         <= lit ? ~sh_dp[idx] : 1'b1;
      frame_done <= boundary;
    end
  end

endmodule
